// File: rtl/aes_dec_pkg.sv
// Shared types and helpers for the AES256 decryption datapath.
package aes_dec_pkg;

    localparam int unsigned N = 4;

    typedef logic [7:0]          byte_t;
    typedef byte_t [N-1:0]       row_t;
    typedef logic [1:0]          row_idx_t;

    // One buffered row: rotated bytes, its row index and a state-complete flag
    typedef struct packed {
        row_t     row;
        row_idx_t idx;
        logic     last;
    } row_entry_t;

    // Inverse ShiftRows rotation: out[i] = in[(i - r) mod 4]
    function automatic row_t inv_rotate(row_t row, row_idx_t r);
        row_t res;
        for (int i = 0; i < int'(N); i++) begin
            res[i] = row[row_idx_t'(row_idx_t'(i) - r)];
        end
        return res;
    endfunction

endpackage

// File: rtl/mod_dec_row_fifo.sv
// DEPTH-entry row FIFO with registered head, valid and ready.
module mod_dec_row_fifo
    import aes_dec_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       push,
    input  row_entry_t wdata,
    input  logic       pop,
    output row_entry_t head,
    output logic       valid,
    output logic       ready
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    row_entry_t       mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;

    logic             do_push;
    logic             do_pop;
    logic [PTR_W-1:0] wr_ptr_nxt;
    logic [PTR_W-1:0] rd_ptr_nxt;
    logic [CNT_W-1:0] count_nxt;
    row_entry_t       head_nxt;

    // Next pointers, occupancy and head entry (bypass the write when it lands at the new head)
    always_comb begin
        do_push    = push && (count < CNT_W'(DEPTH));
        do_pop     = pop && (count != '0);
        wr_ptr_nxt = wr_ptr;
        rd_ptr_nxt = rd_ptr;
        count_nxt  = count;
        if (do_push) begin
            wr_ptr_nxt = (wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : PTR_W'(wr_ptr + PTR_W'(1));
        end
        if (do_pop) begin
            rd_ptr_nxt = (rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : PTR_W'(rd_ptr + PTR_W'(1));
        end
        case ({do_push, do_pop})
            2'b10:   count_nxt = CNT_W'(count + CNT_W'(1));
            2'b01:   count_nxt = CNT_W'(count - CNT_W'(1));
            default: count_nxt = count;
        endcase
        if (do_push && (rd_ptr_nxt == wr_ptr)) begin
            head_nxt = wdata;
        end else begin
            head_nxt = mem[rd_ptr_nxt];
        end
    end

    // Storage writes
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // Pointers, count and registered head/flags; head holds while empty
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            head   <= '0;
            valid  <= 1'b0;
            ready  <= 1'b0;
        end else begin
            wr_ptr <= wr_ptr_nxt;
            rd_ptr <= rd_ptr_nxt;
            count  <= count_nxt;
            valid  <= (count_nxt != '0);
            ready  <= (count_nxt < CNT_W'(DEPTH));
            if (count_nxt != '0) begin
                head <= head_nxt;
            end
        end
    end

endmodule

// File: rtl/mod_dec_inv_shifter.sv
// InvShiftRows stage: tracks row index, rotates rows on write, buffers them for InvSubBytes.
module mod_dec_inv_shifter
    import aes_dec_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               in_first,
    input  logic [N-1:0][7:0]  inp,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [N-1:0][7:0]  outp,
    output logic [1:0]         out_row,
    output logic               out_last,
    output logic               err_sync
);

    row_idx_t   row_cnt;
    row_idx_t   r_c;
    logic       push_c;
    row_entry_t entry_c;
    row_entry_t head;

    // Row index for the incoming row and its rotated buffer entry
    always_comb begin
        push_c        = in_valid && in_ready;
        r_c           = in_first ? row_idx_t'(0) : row_cnt;
        entry_c.row   = inv_rotate(row_t'(inp), r_c);
        entry_c.idx   = r_c;
        entry_c.last  = (r_c == row_idx_t'(3));
    end

    // Row counter and sticky resync error (in_first arriving mid-state)
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            row_cnt  <= '0;
            err_sync <= 1'b0;
        end else if (push_c) begin
            row_cnt <= row_idx_t'(r_c + row_idx_t'(1));
            if (in_first && (row_cnt != '0)) begin
                err_sync <= 1'b1;
            end
        end
    end

    mod_dec_row_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push_c),
        .wdata (entry_c),
        .pop   (out_ready),
        .head  (head),
        .valid (out_valid),
        .ready (in_ready)
    );

    assign outp     = head.row;
    assign out_row  = head.idx;
    assign out_last = head.last;

endmodule
